qru: RTL and testbench

Quotient and remainder unit (QRU) for the RV32M integer functional unit. It is an iterative radix-2 restoring divider that executes DIV, DIVU, REM and REMU on the register-file operands `a` and `b`, and drives `divres` into the integer-functional-unit result mux next to `alures` and `mulres`. The control unit holds the datapath stalled, with `pcnextctl` low and `regwe` low, while `busy` is high. It releases the stall and enables write-back in the cycle `done` is high.

---
 rtl/qru.sv | 137 +++++++++++++
 tb/tb_qru.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/qru.sv
// qru: iterative radix-2 restoring divider executing RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro QRU_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle from start.
module qru #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   divctl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] divres,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_REM = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]    op;
    logic          sign_a, sign_b;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  dvsr, quo, rem;
    logic [CW-1:0] cnt;

    logic [W:0]    rem_sh;
    logic          fits;
    logic [W-1:0]  rem_step, quo_step, quo_fix, rem_fix, result;
    logic          accept, early, last;

    // divctl[0] set = unsigned; divctl[1] set = remainder.
    function automatic logic is_special(input logic [1:0] f, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
        return (y == '0) || (!f[0] && x == {1'b1, {(W-1){1'b0}}} && y == '1);
    endfunction

    function automatic logic [W-1:0] special_res(input logic [1:0] f, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        if (y == '0)
            return f[1] ? x : '1;
        // Signed overflow: the quotient wraps to the dividend itself, remainder is zero.
        return f[1] ? '0 : x;
    endfunction

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(1));

`ifdef QRU_EARLY_OUT_EN
    assign early = is_special(divctl, a, b);
`else
    assign early = 1'b0;
`endif

    // The shifted remainder can reach 2*dvsr-1, so the trial compare needs one extra bit.
    always_comb begin
        rem_sh   = {rem, quo[W-1]};
        fits     = (rem_sh >= {1'b0, dvsr});
        rem_step = fits ? W'(rem_sh - {1'b0, dvsr}) : rem_sh[W-1:0];
        quo_step = {quo[W-2:0], fits};
        quo_fix  = (op == OP_DIV && (sign_a ^ sign_b)) ? -quo_step : quo_step;
        rem_fix  = (op == OP_REM && sign_a) ? -rem_step : rem_step;
        if (is_special(op, a_q, b_q))
            result = special_res(op, a_q, b_q);
        else
            result = op[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = early ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept)
                    state_nxt = early ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the datapath is reset too, so an aborted operation leaves nothing behind in divres.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            dvsr   <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            divres <= '0;
        end else if (accept) begin
            op     <= divctl;
            a_q    <= a;
            b_q    <= b;
            sign_a <= !divctl[0] && a[W-1];
            sign_b <= !divctl[0] && b[W-1];
            quo    <= (!divctl[0] && a[W-1]) ? -a : a;
            dvsr   <= (!divctl[0] && b[W-1]) ? -b : b;
            rem    <= '0;
            cnt    <= CW'(W);
            if (early)
                divres <= special_res(divctl, a, b);
        end else if (state == RUN) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt - CW'(1);
            if (last)
                divres <= result;
        end
    end
endmodule

// File: tb/tb_qru.sv
// tb_qru: directed self-checking bench for qru (W = 32); follows QRU_EARLY_OUT_EN for special-case latency.
`timescale 1ns/1ps
module tb_qru;
    localparam int W = 32;

`ifdef QRU_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 0;
`else
    localparam int SPECIAL_LAT = W;
`endif

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   divctl;
    logic [W-1:0] a, b;
    logic [W-1:0] divres;
    logic         busy, done;

    int tests    = 0;
    int failures = 0;
    int lat, bcyc;

    always #5 clk = ~clk;

    qru #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .divctl (divctl),
        .a      (a),
        .b      (b),
        .divres (divres),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge E0,
    // with operands and opcode already scrambled.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start  = 1'b1;
        divctl = op;
        a      = x;
        b      = y;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        divctl = ~op;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0000_0003;
    endtask

    // lat counts edges after E0 until done is seen; optional start pulse at poke cycle.
    task automatic wait_done(output int l, output int bc, input int poke);
        l  = 0;
        bc = 0;
        while (!done && l < 100) begin
            if (busy)
                bc++;
            start = (poke != 0 && l == poke);
            @(posedge clk);
            @(negedge clk);
            l++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp, input int exp_lat);
        int l, bc;
        launch(op, x, y);
        wait_done(l, bc, 0);
        check({tag, " result"}, divres, exp);
        check({tag, " latency"}, 32'(l), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(bc), 32'(exp_lat));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done pulse"}, W'(done), '0);
        check({tag, " hold"}, divres, exp);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        divctl = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset divres", divres, '0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu 100/7",      DIVU, 32'd100,      32'd7,        32'd14,       W);
        run_op("div -100/7",      DIV,  32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFF2, W);
        run_op("rem -100/7",      REM,  32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFFE, W);
        run_op("remu 100/7",      REMU, 32'd100,      32'd7,        32'd2,        W);
        run_op("div 100/-7",      DIV,  32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, W);
        run_op("rem 100/-7",      REM,  32'd100,      32'hFFFF_FFF9, 32'd2,        W);
        run_op("div -100/-7",     DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,      W);
        run_op("rem -100/-7",     REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, W);
        run_op("divu max/1",      DIVU, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, W);
        run_op("remu max/big",    REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, W);
        run_op("div min/1",       DIV,  32'h8000_0000, 32'd1,       32'h8000_0000, W);
        run_op("divu min/max",    DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       W);

        run_op("div 5/0",         DIV,  32'd5,        32'd0,        32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("rem 5/0",         REM,  32'd5,        32'd0,        32'd5,        SPECIAL_LAT);
        run_op("rem -100/0",      REM,  32'hFFFF_FF9C, 32'd0,       32'hFFFF_FF9C, SPECIAL_LAT);
        run_op("divu 5/0",        DIVU, 32'd5,        32'd0,        32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("remu -7/0",       REMU, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9, SPECIAL_LAT);
        run_op("div overflow",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        run_op("rem overflow",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       SPECIAL_LAT);

        // Back-to-back: second start lands in the DONE cycle, with stray start pulses during RUN.
        launch(DIV, 32'hFFFF_FF9C, 32'd7);
        wait_done(lat, bcyc, 0);
        check("b2b first result", divres, 32'hFFFF_FFF2);
        launch(DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
        wait_done(lat, bcyc, 5);
        check("b2b second result", divres, 32'h0FFF_FFFF);
        check("b2b second latency", 32'(lat), 32'(W));
        check("b2b second busy", 32'(bcyc), 32'(W));
        @(posedge clk);
        @(negedge clk);
        check("b2b idle done", W'(done), '0);

        // Reset mid-operation.
        launch(DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", W'(busy), '0);
        check("abort done", W'(done), '0);
        check("abort divres", divres, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort stays idle", W'(busy), '0);
        run_op("divu 9/3 after reset", DIVU, 32'd9, 32'd3, 32'd3, W);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
